// File: rtl/d_mem_wait_responder.sv
// Word-addressed data memory behind a valid/ready request/response handshake.
// Every access spends WAIT_CYCLES extra cycles before committing and answering,
// so load/store logic can be exercised against a multi-cycle memory.
module d_mem_wait_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] readData,
  output logic        resp_err
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e        state_q;
  logic [7:0]    cnt_q;
  logic          write_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;

  // Not reset: contents survive a reset pulse.
  logic [31:0]   mem [DEPTH_WORDS];

  logic          addr_err;
  logic [IdxW-1:0] idx;
  logic          commit;

  // Decode the captured address; commit happens on the last wait edge only.
  always_comb begin
    addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
    idx      = addr_q[IdxW+1:2];
    commit   = (state_q == StWait) && (cnt_q == 8'd0) && !addr_err;
  end

  // Gated by reset so the responder never advertises readiness while held in reset.
  assign req_ready = (state_q == StIdle) && reset;

  // Store commit; an async reset returns the FSM to idle, which blocks the commit.
  always_ff @(posedge clk) begin
    if (commit && write_q) begin
      mem[idx] <= wdata_q;
    end
  end

  // Request capture, wait countdown and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      write_q    <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      resp_valid <= 1'b0;
      readData   <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= address;
            wdata_q <= writeData;
            cnt_q   <= 8'(WAIT_CYCLES);
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_err   <= addr_err;
            // Loads see the array contents from before this edge.
            readData   <= (!addr_err && !write_q) ? mem[idx] : 32'd0;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q    <= StIdle;
            resp_valid <= 1'b0;
            readData   <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_d_mem_wait_responder.sv
// Bench for d_mem_wait_responder: one instance with two wait states and one with
// none, driven in turn; expectations come from a per-instance word-array model.
module tb_d_mem_wait_responder;

  localparam int unsigned Depth = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;  // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=0 instance
  logic        req_valid, req_write, resp_ready;
  logic [31:0] address, writeData;

  logic        rr_a, rv_a, er_a, rr_b, rv_b, er_b;
  logic [31:0] rd_a, rd_b;
  logic        rr, rv, er;
  logic [31:0] rd;

  d_mem_wait_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(2)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid && !sel),
    .req_ready (rr_a),
    .req_write (req_write),
    .address   (address),
    .writeData (writeData),
    .resp_valid(rv_a),
    .resp_ready(resp_ready && !sel),
    .readData  (rd_a),
    .resp_err  (er_a)
  );

  d_mem_wait_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(0)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid && sel),
    .req_ready (rr_b),
    .req_write (req_write),
    .address   (address),
    .writeData (writeData),
    .resp_valid(rv_b),
    .resp_ready(resp_ready && sel),
    .readData  (rd_b),
    .resp_err  (er_b)
  );

  assign rr = sel ? rr_b : rr_a;
  assign rv = sel ? rv_b : rv_a;
  assign er = sel ? er_b : er_a;
  assign rd = sel ? rd_b : rd_a;

  logic [31:0] model [2][Depth];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(Depth));
  endfunction

  function automatic int wait_cur();
    return sel ? 0 : 2;
  endfunction

  // Full access from a negedge: accept, latency, response, optional backpressure, release.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, input int bp);
    int n;
    int edges;
    bit e;
    logic [31:0] exp_rd;
    e = is_err(a);
    exp_rd = (e || wr) ? 32'h0 : model[sel][a[9:2]];
    req_valid = 1'b1; req_write = wr; address = a; writeData = d; resp_ready = 1'b0;
    n = 0;
    while (rr !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'b0, rr}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("busy_not_ready", {31'b0, rr}, 32'd0);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (rv !== 1'b1 && edges < 300);
    check("latency", 32'(edges), 32'(wait_cur() + 1));
    check("resp_err", {31'b0, er}, {31'b0, e});
    check("readData", rd, exp_rd);
    if (!e && wr) model[sel][a[9:2]] = d;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check("bp_flags", {29'b0, rv, rr, er}, {29'b0, 1'b1, 1'b0, e});
      check("bp_data", rd, exp_rd);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("after_hs_flags", {29'b0, rv, rr, er}, {29'b0, 1'b0, 1'b1, 1'b0});
    check("after_hs_data", rd, 32'h0);
    @(negedge clk);
  endtask

  // Hold a load request and resp_ready high; accepts must be exactly WAIT+3 apart.
  task automatic burst(input logic [31:0] a, input int n_acc);
    int acc_cyc[$];
    int cyc;
    int n;
    cyc = 0;
    req_valid = 1'b1; req_write = 1'b0; address = a; resp_ready = 1'b1;
    while (cyc < 200) begin
      if (rv === 1'b1) check("burst_data", rd, model[sel][a[9:2]]);
      if (rr === 1'b1) acc_cyc.push_back(cyc);
      if (acc_cyc.size() >= n_acc) break;
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("burst_count", 32'(acc_cyc.size()), 32'(n_acc));
    for (int i = 1; i < acc_cyc.size(); i++)
      check("burst_period", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(wait_cur() + 3));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rv === 1'b1) check("burst_last_data", rd, model[sel][a[9:2]]);
    end while (rr !== 1'b1 && n < 50);
    check("burst_drain", {31'b0, rr}, 32'd1);
    resp_ready = 1'b0;
  endtask

  // Issue a request from a negedge and stop once resp_valid is seen (no handshake).
  task automatic start_until_resp(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = wr; address = a; writeData = d; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rv !== 1'b1 && n < 300);
    check("resp_seen", {31'b0, rv}, 32'd1);
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_flags"}, {29'b0, rr, rv, er}, 32'd0);
    check({tag, "_data"}, rd, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    sel = 1'b0; reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    address = 32'h0; writeData = 32'h0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("reset_flags", {29'b0, rr, rv, er}, 32'd0);
      check("reset_data", rd, 32'h0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Give every word a known value in both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      for (int i = 0; i < int'(Depth); i++) access(1'b1, 32'(i * 4), $urandom, 0);
    end

    sel = 1'b0;
    @(negedge clk);
    access(1'b1, 32'h10, 32'hDEADBEEF, 0);
    access(1'b0, 32'h10, 32'h0, 0);
    access(1'b0, 32'h12, 32'h0, 0);
    access(1'b0, 32'h10, 32'h0, 0);
    access(1'b1, 32'h400, 32'h55AA55AA, 0);
    access(1'b0, 32'h3FC, 32'h0, 0);
    access(1'b0, 32'h10, 32'h0, 5);

    // Reset one wait edge into a store: the store must never land.
    req_valid = 1'b1; req_write = 1'b1; address = 32'h20; writeData = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset_pulse("rst_wait");
    access(1'b0, 32'h20, 32'h0, 0);

    // Reset while a store response is pending: the store already committed.
    start_until_resp(1'b1, 32'h24, 32'hA5A5A5A5);
    model[0][9] = 32'hA5A5A5A5;
    reset_pulse("rst_resp_store");
    access(1'b0, 32'h24, 32'h0, 0);

    // Reset while a load response is pending: the response is dropped.
    start_until_resp(1'b0, 32'h10, 32'h0);
    check("resp_load_data", rd, model[0][4]);
    reset_pulse("rst_resp_load");

    burst(32'h10, 4);

    sel = 1'b1;
    @(negedge clk);
    access(1'b0, 32'h10, 32'h0, 0);
    access(1'b1, 32'h10, 32'hCAFEF00D, 2);
    burst(32'h10, 5);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      for (int i = 0; i < 60; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0) a = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        else if (r == 1) a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
        else a = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
